shmem_rr_arbiter: RTL
=====================

# shmem_rr_arbiter

Round-robin arbiter that shares the single shared-memory request port of the CGRA among `NUM_REQ` synchronous request FIFOs. Each cycle it picks one non-empty FIFO, pulses that FIFO's `read_en`, and presents the popped word to the shared-memory port one cycle later under a valid/ready handshake. It sits between the per-PE request FIFOs (which expose `req` = registered non-empty and a registered `read_data`) and the shared-memory controller.

## Interface
- `NUM_REQ`, 4: number of requester FIFOs; must be ≥ 2.
- `FIFO_WIDTH`, 32: width of one request word.
- `IDX_W`, 2: width of a requester index; equals clog2(`NUM_REQ`).

- `clk`, in, 1: single clock, all logic on its rising edge.
- `rst_n`, in, 1: reset. Synchronous and active-low.
- `fifo_req`, in, `NUM_REQ`: bit i high means FIFO i is non-empty (FIFO's registered `req`).
- `fifo_rd_data`, in, `NUM_REQ*FIFO_WIDTH`: concatenated FIFO `read_data`; slice i is bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- `fifo_rd_en`, out, `NUM_REQ`: one-hot-or-zero pop strobe to the FIFOs; combinational.
- `mem_valid`, out, 1: `mem_data`/`mem_src` hold a request.
- `mem_ready`, in, 1: shared memory accepts the request this cycle.
- `mem_data`, out, `FIFO_WIDTH`: request word, zero when `mem_valid`=0.
- `mem_src`, out, `IDX_W`: index of the FIFO that supplied `mem_data`.
- `gnt_count`, out, 16: total accepted handshakes, saturating at 16'hFFFF.

## Operation
- State: `ptr` (IDX_W, priority pointer), `s1_valid`, `s1_src` (IDX_W), `gnt_count`.
- Advance condition: `adv = !s1_valid || mem_ready`.
- Pick: search `fifo_req` starting at index `ptr`, increasing, wrapping from `NUM_REQ-1` to 0. The first set bit is winner `w`. If there is no set bit, there is no winner.
- Issue: if `adv` and a winner exists, `fifo_rd_en[w]`=1 and all other bits are 0. Otherwise `fifo_rd_en`=0.
- On a clock edge with issue: `s1_valid`<=1, `s1_src`<=w, and `ptr`<=(w+1) mod `NUM_REQ`.
- On a clock edge with `adv` and no issue: `s1_valid`<=0, and `ptr` is unchanged.
- When `adv`=0 (stalled): `s1_valid`, `s1_src` and `ptr` hold, and no FIFO is popped. The stalled FIFO's `read_data` therefore stays stable.
- Outputs: `mem_valid`=`s1_valid`, `mem_src`=`s1_src`.
- `mem_data` = slice `s1_src` of `fifo_rd_data` when `s1_valid`=1, else 0. This is a combinational mux of registered inputs.
- Handshake: the request transfers in a cycle where `mem_valid` && `mem_ready`. `gnt_count` increments on each transfer, saturating.
- Reset (`rst_n` low at a clock edge), including mid-stall:
  - `ptr`=0, `s1_valid`=0, `s1_src`=0, `gnt_count`=0.
  - `fifo_rd_en` is forced to 0 combinationally while `rst_n`=0.
  - A word that was popped but not accepted is dropped; the FIFOs are reset by the same `rst_n`.

## Timing
- Latency: `fifo_req` high in cycle t with the arbiter free gives `fifo_rd_en` in cycle t and `mem_valid` in t+1.
- Throughput: one transfer per cycle while `mem_ready`=1 and any `fifo_req` is set.
- Reset values: `mem_valid`=0, `mem_data`=0, `mem_src`=0, `gnt_count`=0, `fifo_rd_en`=0.
- Popping FIFO w at cycle t with `mem_ready`=1 and w winning again at t+1 is legal: the FIFO updates `read_data` on the same edge the previous word is accepted.
- A FIFO holding one entry that is popped in cycle t drops `fifo_req` at t+1, so there is no double pop.
- `mem_ready` high while `mem_valid`=0 is ignored. `mem_valid` never drops without a transfer, except on reset.

## Structure
- Package `shmem_arb_pkg` holds:
  - the defaults `NUM_REQ`, `FIFO_WIDTH` and `IDX_W`;
  - the constant `GNT_CNT_W`=16;
  - a rotate-and-priority-encode function for reuse by other arbiters.
- Sub-module `rr_pick`: combinational. Takes `req[NUM_REQ]` and `ptr[IDX_W]`; outputs `found` and `idx[IDX_W]`.
- Top-level `shmem_rr_arbiter` holds the registers, the handshake and the data mux.

## Test plan
- Reset, then `fifo_req`=0000 for 5 cycles → `fifo_rd_en`=0, `mem_valid`=0, `mem_data`=0, `gnt_count`=0.
- `fifo_req`=1111 held, `mem_ready`=1, 8 cycles → `mem_src` sequence is 0,1,2,3,0,1,2,3 starting at cycle 1; `gnt_count`=8 (plus any transfer in the final cycle).
- FIFO2 holds 0xA5A5_0002, FIFO3 holds 0x0000_0003, `ptr`=3 → pop 3 first, then 2; `mem_data` = 0x0000_0003, then 0xA5A5_0002.
- `fifo_req`=0011, `mem_ready`=0 for 4 cycles → exactly one pop (FIFO0). `mem_valid` and `mem_data` stay stable. After `mem_ready`=1, FIFO1 is popped in the accept cycle.
- `rst_n` pulled low during a stall with `mem_valid`=1 → at the next edge `mem_valid`=0, `ptr`=0, `gnt_count`=0, and `fifo_rd_en`=0 throughout reset.
- Force `gnt_count` to 16'hFFFE, then do 3 transfers → the count ends at 16'hFFFF.

Source files
------------

// File: rtl/shmem_arb_pkg.sv
// Shared constants and the rotate-and-priority-encode helper for the
// shared-memory round-robin arbiters.
package shmem_arb_pkg;

  localparam int NUM_REQ    = 4;
  localparam int FIFO_WIDTH = 32;
  localparam int IDX_W      = 2;
  localparam int GNT_CNT_W  = 16;

  // Upper bound on requesters the generic picker can handle.
  localparam int PICK_MAX   = 64;
  localparam int PICK_IDX_W = 6;

  typedef struct packed {
    logic                  found;
    logic [PICK_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req[0..n-1] at or after ptr, wrapping. Iterating from the
  // far end lets the closest-to-ptr hit overwrite the others.
  function automatic pick_t rr_pick_fn(input logic [PICK_MAX-1:0]   req,
                                       input logic [PICK_IDX_W-1:0] ptr,
                                       input int                    n);
    pick_t r;
    int    k;
    r = '0;
    for (int i = PICK_MAX - 1; i >= 0; i--) begin
      if (i < n) begin
        k = int'(ptr) + i;
        if (k >= n) k = k - n;
        if (req[k[PICK_IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = k[PICK_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shmem_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr.
module rr_pick
  import shmem_arb_pkg::*;
#(
  parameter int NUM_REQ = shmem_arb_pkg::NUM_REQ,
  parameter int IDX_W   = shmem_arb_pkg::IDX_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  pick_t pick;

  assign pick  = rr_pick_fn(PICK_MAX'(req), PICK_IDX_W'(ptr), NUM_REQ);
  assign found = pick.found;
  assign idx   = IDX_W'(pick.idx);

endmodule

// File: rtl/shmem_rr_arbiter.sv
// Round-robin arbiter sharing the single shared-memory request port among
// NUM_REQ request FIFOs; one pop per cycle, word presented one cycle later.
module shmem_rr_arbiter
  import shmem_arb_pkg::*;
#(
  parameter int NUM_REQ    = shmem_arb_pkg::NUM_REQ,
  parameter int FIFO_WIDTH = shmem_arb_pkg::FIFO_WIDTH,
  parameter int IDX_W      = shmem_arb_pkg::IDX_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            fifo_req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] fifo_rd_data,
  output logic [NUM_REQ-1:0]            fifo_rd_en,
  output logic                          mem_valid,
  input  logic                          mem_ready,
  output logic [FIFO_WIDTH-1:0]         mem_data,
  output logic [IDX_W-1:0]              mem_src,
  output logic [GNT_CNT_W-1:0]          gnt_count
);

  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     s1_src_q, s1_src_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [GNT_CNT_W-1:0] gnt_q, gnt_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic                 adv, issue, xfer;
  logic [FIFO_WIDTH-1:0] slice [NUM_REQ];

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (fifo_req),
    .ptr   (ptr_q),
    .found (win_found),
    .idx   (win_idx)
  );

  // The output stage is free when empty or draining this cycle.
  assign adv   = !s1_valid_q || mem_ready;
  assign issue = adv && win_found;
  assign xfer  = s1_valid_q && mem_ready;

  always_comb begin
    fifo_rd_en = '0;
    if (issue && rst_n) fifo_rd_en[win_idx] = 1'b1;
  end

  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = s1_valid_q;
    s1_src_d   = s1_src_q;
    gnt_d      = gnt_q;
    if (adv) begin
      s1_valid_d = win_found;
      if (win_found) begin
        s1_src_d = win_idx;
        ptr_d    = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
    if (xfer && (gnt_q != '1)) gnt_d = gnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_src_q   <= '0;
      gnt_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_src_q   <= s1_src_d;
      gnt_q      <= gnt_d;
    end
  end

  // FIFO read_data is registered and held while stalled, so a plain mux suffices.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slice[g] = fifo_rd_data[g*FIFO_WIDTH +: FIFO_WIDTH];
  end

  assign mem_valid = s1_valid_q;
  assign mem_src   = s1_src_q;
  assign mem_data  = s1_valid_q ? slice[s1_src_q] : '0;
  assign gnt_count = gnt_q;

endmodule
